// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor on the 48 MHz reference clock: pulses the PLL reset,
// qualifies lock, gates downstream reset and tracks relock/timeout status.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 48,
  parameter int LOCK_STABLE_CYCLES  = 4800,
  parameter int LOCK_TIMEOUT_CYCLES = 480000,
  parameter int LOSS_FILTER_CYCLES  = 4,
  parameter int CNT_W               = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_RESET_PLL   = 2'd0,
    S_WAIT_LOCK   = 2'd1,
    S_STABLE_WAIT = 2'd2,
    S_RUN         = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_LIM    = CNT_W'(LOSS_FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q, sync_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic [7:0]       relock_count_q, relock_count_d;
  logic             timeout_err_q, timeout_err_d;
  logic             relock;
  logic             lk;

  assign lk = sync_q[1];

  always_comb begin
    sync_d         = {sync_q[0], pll_locked};
    state_d        = state_q;
    cnt_d          = cnt_q;
    timeout_err_d  = timeout_err_q;
    relock_count_d = relock_count_q;
    relock         = 1'b0;

    case (state_q)
      S_RESET_PLL: begin
        // force_relock deliberately ignored: the pulse always runs to length
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        if (force_relock) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
        end else if (lk) begin
          state_d = S_STABLE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d       = S_RESET_PLL;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STABLE_WAIT: begin
        if (force_relock) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
        end else if (!lk) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        // counter holds the run of consecutive unlocked samples
        if (force_relock || cnt_q == LOSS_LIM) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
          relock  = 1'b1;
        end else if (!lk) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = S_RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    if (relock && relock_count_q != 8'hFF)
      relock_count_d = relock_count_q + 8'd1;

    pll_rst_d = (state_d == S_RESET_PLL);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q        <= S_RESET_PLL;
      cnt_q          <= '0;
      sync_q         <= '0;
      pll_rst_q      <= 1'b1;
      sys_rst_q      <= 1'b1;
      ready_q        <= 1'b0;
      relock_count_q <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sync_q         <= sync_d;
      pll_rst_q      <= pll_rst_d;
      sys_rst_q      <= sys_rst_d;
      ready_q        <= ready_d;
      relock_count_q <= relock_count_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign sys_rst      = sys_rst_q;
  assign ready        = ready_q;
  assign relock_count = relock_count_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with P=4, S=16, T=100, L=3.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b1;
  logic       force_relock = 1'b0;
  logic       pll_rst, sys_rst, ready, timeout_err;
  logic [7:0] relock_count;

  int checks = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES(4), .LOCK_STABLE_CYCLES(16), .LOCK_TIMEOUT_CYCLES(100),
    .LOSS_FILTER_CYCLES(3), .CNT_W(20)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .force_relock(force_relock),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready),
    .relock_count(relock_count), .timeout_err(timeout_err)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    int         n;
    logic       lock;
    logic       frc;
    logic       e_prst;
    logic       e_srst;
    logic       e_rdy;
    logic [7:0] e_cnt;
    logic       e_terr;
  } vec_t;

  vec_t tbl[22];

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic check(input string name, input logic prst, input logic srst,
                       input logic rdy, input logic [7:0] cnt, input logic terr);
    logic [11:0] got, exp;
    got = {pll_rst, sys_rst, ready, relock_count, timeout_err};
    exp = {prst, srst, rdy, cnt, terr};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got pll_rst=%b sys_rst=%b ready=%b cnt=%0d terr=%b, want pll_rst=%b sys_rst=%b ready=%b cnt=%0d terr=%b",
               name, pll_rst, sys_rst, ready, relock_count, timeout_err, prst, srst, rdy, cnt, terr);
    end
  endtask

  task automatic wait_ready(input string name, input int bound);
    int k = 0;
    while (ready !== 1'b1 && k < bound) begin
      step(1);
      k++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: ready=%b after %0d edges, want 1", name, ready, bound);
    end
  endtask

  // hold reset across an edge, then release just after an edge so the next edge is edge 1
  task automatic do_reset(input logic lock);
    pll_locked   = lock;
    force_relock = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic relock_once(input string name);
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    wait_ready(name, 40);
  endtask

  initial begin
    //            n  lk frc prst srst rdy cnt terr
    tbl[0]  = '{ 1, 1, 0, 1, 1, 0, 8'd0, 0};  // edge 1
    tbl[1]  = '{ 2, 1, 0, 1, 1, 0, 8'd0, 0};  // edge 3
    tbl[2]  = '{ 1, 1, 0, 0, 1, 0, 8'd0, 0};  // edge 4: pulse ends
    tbl[3]  = '{16, 1, 0, 0, 1, 0, 8'd0, 0};  // edge 20
    tbl[4]  = '{ 1, 1, 0, 0, 0, 1, 8'd0, 0};  // edge 21: RUN
    tbl[5]  = '{ 2, 0, 0, 0, 0, 1, 8'd0, 0};  // 2-cycle glitch
    tbl[6]  = '{ 4, 1, 0, 0, 0, 1, 8'd0, 0};  // filtered out
    tbl[7]  = '{ 3, 0, 0, 0, 0, 1, 8'd0, 0};  // 3-cycle loss, first low at edge 28
    tbl[8]  = '{ 2, 1, 0, 0, 0, 1, 8'd0, 0};  // edge 32 still RUN
    tbl[9]  = '{ 1, 1, 0, 1, 1, 0, 8'd1, 0};  // edge 33 = 28+5
    tbl[10] = '{ 4, 1, 0, 0, 1, 0, 8'd1, 0};  // edge 37
    tbl[11] = '{16, 1, 0, 0, 1, 0, 8'd1, 0};  // edge 53
    tbl[12] = '{ 1, 1, 0, 0, 0, 1, 8'd1, 0};  // edge 54 = 33+21
    tbl[13] = '{ 1, 1, 1, 1, 1, 0, 8'd2, 0};  // force in RUN
    tbl[14] = '{ 4, 1, 0, 0, 1, 0, 8'd2, 0};  // edge 59
    tbl[15] = '{17, 1, 0, 0, 0, 1, 8'd2, 0};  // edge 76
    tbl[16] = '{ 3, 0, 0, 0, 0, 1, 8'd2, 0};  // loss starting edge 77
    tbl[17] = '{ 2, 0, 0, 0, 0, 1, 8'd2, 0};  // edge 81
    tbl[18] = '{ 1, 0, 1, 1, 1, 0, 8'd3, 0};  // edge 82: loss + force, one increment
    tbl[19] = '{ 1, 1, 0, 1, 1, 0, 8'd3, 0};  // edge 83
    tbl[20] = '{ 3, 1, 0, 0, 1, 0, 8'd3, 0};  // edge 86
    tbl[21] = '{17, 1, 0, 0, 0, 1, 8'd3, 0};  // edge 103

    step(2);
    check("reset_state", 1, 1, 0, 8'd0, 0);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      pll_locked   = tbl[i].lock;
      force_relock = tbl[i].frc;
      step(1);
      force_relock = 1'b0;
      if (tbl[i].n > 1) step(tbl[i].n - 1);
      check($sformatf("vec%0d", i), tbl[i].e_prst, tbl[i].e_srst, tbl[i].e_rdy,
            tbl[i].e_cnt, tbl[i].e_terr);
    end

    // bring count to 7, then reset asynchronously between edges
    for (int i = 0; i < 4; i++) relock_once("relock_to7");
    check("count_7", 0, 0, 1, 8'd7, 0);
    #2 rst = 1'b1;
    #1 check("async_reset", 1, 1, 0, 8'd0, 0);
    step(1);

    // stability restart: one low sample at edge 13 kills qualification at edge 15
    do_reset(1'b1);
    step(12);
    check("stab_pre", 0, 1, 0, 8'd0, 0);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(8);
    check("stab_edge21", 0, 1, 0, 8'd0, 0);
    step(10);
    check("stab_edge31", 0, 1, 0, 8'd0, 0);
    step(1);
    check("stab_edge32", 0, 0, 1, 8'd0, 0);

    // lock timeout, then force_relock in WAIT_LOCK
    do_reset(1'b0);
    step(4);
    check("to_edge4", 0, 1, 0, 8'd0, 0);
    step(99);
    check("to_edge103", 0, 1, 0, 8'd0, 0);
    step(1);
    check("to_edge104", 1, 1, 0, 8'd0, 1);
    step(3);
    check("to_edge107", 1, 1, 0, 8'd0, 1);
    step(1);
    check("to_edge108", 0, 1, 0, 8'd0, 1);
    step(1);
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    check("force_wait", 1, 1, 0, 8'd0, 1);
    pll_locked = 1'b1;
    wait_ready("to_relock", 40);
    check("to_sticky", 0, 0, 1, 8'd0, 1);

    // saturation
    do_reset(1'b1);
    wait_ready("sat_start", 40);
    for (int i = 0; i < 254; i++) relock_once("sat_loop");
    check("sat_254", 0, 0, 1, 8'd254, 0);
    relock_once("sat_255");
    check("sat_255", 0, 0, 1, 8'd255, 0);
    for (int i = 0; i < 5; i++) relock_once("sat_more");
    check("sat_260", 0, 0, 1, 8'd255, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
